mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Two-master arbiter for the single-port 16-bit memory shared by the CPU FSM (master 0) and a program loader/debug port (master 1).
- Grants at most one master per cycle.
- Muxes address, RW and write data onto the memory bus.
- Routes returned read data back with a per-master valid strobe.
- Round-robin arbitration with an optional lock for multi-word sequences, plus a hold limit so a locked master cannot starve the other.

Parameters:
N, 16, address and data width
MAX_HOLD, 8, max consecutive cycles a locked master keeps the bus while the other master requests (>=2)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
m0_req  in  1  master 0 requests a transfer this cycle
m0_lock  in  1  master 0 asks to keep the bus after this transfer
m0_rw  in  1  1=read, 0=write (memory convention)
m0_addr  in  N  master 0 address
m0_wdata  in  N  master 0 write data
m0_gnt  out  1  master 0 owns the bus this cycle
m0_rvalid  out  1  rdata is valid for master 0
m1_req, m1_lock, m1_rw, m1_addr, m1_wdata  in  1,1,1,N,N  same as master 0
m1_gnt, m1_rvalid  out  1,1  same as master 0
rdata  out  N  read data returned to both masters, qualified by mK_rvalid
mem_addr  out  N  memory Address
mem_rw  out  1  memory RW
mem_wdata  out  N  to memory Din
mem_rdata  in  N  from memory Dout, valid the cycle after a read is issued

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, rr pointer=0 (master 0 preferred), hold_cnt=0.
  - m0_gnt=m1_gnt=0, m0_rvalid=m1_rvalid=0.
  - mem_rw=1, mem_addr=0, mem_wdata=0.
  - A read in flight is discarded; no rvalid follows reset release.
- States: IDLE, OWN0, OWN1. mK_gnt = (state==OWNk), decoded from registered state, so glitch-free.
- Transfer: occurs in a cycle where mK_gnt && mK_req.
  - mem_* driven combinationally from master K.
  - Writes complete that cycle.
  - Reads: mK_rvalid=1 on the next cycle (registered); rdata = mem_rdata that cycle.
- Bus parking: in a cycle with no transfer (IDLE, or owner req=0), mem_rw=1, mem_addr=0, mem_wdata=0. A spurious write is never possible.
- Next-state, evaluated each edge (o = other master):
  - IDLE:
    - neither req -> IDLE.
    - one req -> OWN of that master.
    - both req -> OWN[rr]; rr then points to the other master.
  - OWNk with mk_req=0:
    - mo_req -> OWNo.
    - otherwise -> IDLE.
  - OWNk with mk_req=1, mo_req=0 -> stay OWNk.
  - OWNk with mk_req=1, mo_req=1:
    - mk_lock=0 -> OWNo (one-transfer alternation, no dead cycle).
    - mk_lock=1 and hold_cnt<MAX_HOLD-1 -> stay, hold_cnt++.
    - mk_lock=1 and hold_cnt==MAX_HOLD-1 -> forced OWNo.
- hold_cnt:
  - Clears on every ownership change and whenever mo_req=0.
  - Width is clog2(MAX_HOLD) and never wraps.
- rr pointer updates on every grant change to point to the master that did not receive the new grant.
- Grant latency: a request from IDLE is granted on the next cycle, so the first transfer occurs 1 cycle after req rises.
- Requester rule: mK_addr, mK_rw and mK_wdata are held stable while mK_req=1 && !mK_gnt.
- Simultaneous events:
  - Last-cycle read by the old owner plus a handover in the same edge: rvalid still goes to the old owner next cycle, even though gnt has moved.
  - m0_rvalid and m1_rvalid are never both 1.
- Lock with no other requester has no effect on timing.

Test Plan:
- Reset: reset=0 mid-read by m0 -> all gnt/rvalid 0, mem_rw=1, mem_addr=0; after release, no rvalid for the aborted read.
- Single master: m0 reads addr 0x0010 (mem returns 0xBEEF) -> m0_gnt at cycle 1; m0_rvalid=1 and rdata=0xBEEF at cycle 2; m1_rvalid stays 0.
- Contention, no lock: both req continuously from IDLE -> grants m0,m1,m0,m1...; m0 writes 0x1234 to 0x0020 and m1 reads 0x0020 on the next slot -> m1 gets 0x1234.
- Lock limit: m1 lock=1 owns the bus, m0 requests with MAX_HOLD=8 -> m1 keeps gnt exactly 8 consecutive cycles after m0_req rises, then m0_gnt=1.
- Handover read: m0 final read at 0x0030, same edge m1 takes the bus -> m0_rvalid (not m1) next cycle with mem_rdata; m1's write is issued that same cycle.
- Idle parking: no requests for 10 cycles -> mem_rw=1 and mem_addr=0 every cycle; ST assertion shows no writes.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master round-robin arbiter with lock and hold limit for a shared 16-bit memory
module mem_bus_arbiter #(
    parameter int N        = 16,
    parameter int MAX_HOLD = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         m0_req,
    input  logic         m0_lock,
    input  logic         m0_rw,
    input  logic [N-1:0] m0_addr,
    input  logic [N-1:0] m0_wdata,
    output logic         m0_gnt,
    output logic         m0_rvalid,
    input  logic         m1_req,
    input  logic         m1_lock,
    input  logic         m1_rw,
    input  logic [N-1:0] m1_addr,
    input  logic [N-1:0] m1_wdata,
    output logic         m1_gnt,
    output logic         m1_rvalid,
    output logic [N-1:0] rdata,
    output logic [N-1:0] mem_addr,
    output logic         mem_rw,
    output logic [N-1:0] mem_wdata,
    input  logic [N-1:0] mem_rdata
);

    // Hold counter only ever reaches MAX_HOLD-1 before ownership is forced away.
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_rr;          // 0: master 0 wins the next tie, 1: master 1 wins
    logic          w_rr_next;
    logic [HW-1:0] r_hold;
    logic [HW-1:0] w_hold_next;
    logic          r_m0_rvalid;
    logic          r_m1_rvalid;
    logic          w_xfer0;
    logic          w_xfer1;

    // Grants come straight from the registered state so they cannot glitch.
    assign m0_gnt    = (r_state == OWN0);
    assign m1_gnt    = (r_state == OWN1);
    assign w_xfer0   = m0_gnt && m0_req;
    assign w_xfer1   = m1_gnt && m1_req;
    assign m0_rvalid = r_m0_rvalid;
    assign m1_rvalid = r_m1_rvalid;
    assign rdata     = mem_rdata;

    // Bus mux: the transferring master drives the memory, otherwise park as a read of address 0.
    always_comb begin
        mem_rw    = 1'b1;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_xfer0) begin
            mem_rw    = m0_rw;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else if (w_xfer1) begin
            mem_rw    = m1_rw;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end
    end

    // Next ownership and hold count; hold defaults to zero so any handover or lone owner clears it.
    always_comb begin
        w_next      = r_state;
        w_hold_next = '0;
        case (r_state)
            IDLE: begin
                if (m0_req && m1_req) begin
                    w_next = r_rr ? OWN1 : OWN0;
                end else if (m0_req) begin
                    w_next = OWN0;
                end else if (m1_req) begin
                    w_next = OWN1;
                end else begin
                    w_next = IDLE;
                end
            end
            OWN0: begin
                if (!m0_req) begin
                    w_next = m1_req ? OWN1 : IDLE;
                end else if (m1_req) begin
                    if (!m0_lock || (r_hold == HOLD_LAST)) begin
                        w_next = OWN1;
                    end else begin
                        w_hold_next = r_hold + 1'b1;
                    end
                end
            end
            OWN1: begin
                if (!m1_req) begin
                    w_next = m0_req ? OWN0 : IDLE;
                end else if (m0_req) begin
                    if (!m1_lock || (r_hold == HOLD_LAST)) begin
                        w_next = OWN0;
                    end else begin
                        w_hold_next = r_hold + 1'b1;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Round-robin pointer moves to the loser whenever a new grant is handed out.
    always_comb begin
        w_rr_next = r_rr;
        if (w_next != r_state) begin
            if (w_next == OWN0) begin
                w_rr_next = 1'b1;
            end else if (w_next == OWN1) begin
                w_rr_next = 1'b0;
            end
        end
    end

    // State, pointer, hold count and read-return strobes; reset discards any read in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_rr        <= 1'b0;
            r_hold      <= '0;
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_rr        <= w_rr_next;
            r_hold      <= w_hold_next;
            r_m0_rvalid <= w_xfer0 && m0_rw;
            r_m1_rvalid <= w_xfer1 && m1_rw;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_lock, m0_rw;
    logic [15:0] m0_addr, m0_wdata;
    logic        m0_gnt, m0_rvalid;
    logic        m1_req, m1_lock, m1_rw;
    logic [15:0] m1_addr, m1_wdata;
    logic        m1_gnt, m1_rvalid;
    logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_rw;

    logic [15:0] mem_model [0:255];
    int          n_tests = 0;
    int          n_fail  = 0;

    mem_bus_arbiter #(.N(16), .MAX_HOLD(8)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_rw(m0_rw),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_rw(m1_rw),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .rdata(rdata), .mem_addr(mem_addr), .mem_rw(mem_rw),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous memory: write on the edge, read data appears the cycle after the read.
    always @(posedge clk) begin
        if (!reset) begin
            mem_model[8'h10] = 16'hBEEF;
            mem_model[8'h30] = 16'hCAFE;
        end else if (!mem_rw) begin
            mem_model[mem_addr[7:0]] = mem_wdata;
        end else begin
            mem_rdata <= mem_model[mem_addr[7:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        m0_req = 0; m0_lock = 0; m0_rw = 1; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_lock = 0; m1_rw = 1; m1_addr = 0; m1_wdata = 0;
        nxt(); nxt();
        smp();
        chk("rst_m0_gnt", m0_gnt, 0);
        chk("rst_m1_gnt", m1_gnt, 0);
        chk("rst_m0_rvalid", m0_rvalid, 0);
        chk("rst_m1_rvalid", m1_rvalid, 0);
        chk("rst_mem_rw", mem_rw, 1);
        chk("rst_mem_addr", mem_addr, 0);

        // Reset in the middle of a read by m0
        nxt();
        reset = 1'b1;
        m0_req = 1; m0_rw = 1; m0_addr = 16'h0010;
        nxt();
        smp();
        chk("midrd_gnt_before", m0_gnt, 1);
        reset = 1'b0;
        #1;
        chk("midrd_m0_gnt", m0_gnt, 0);
        chk("midrd_mem_rw", mem_rw, 1);
        chk("midrd_mem_addr", mem_addr, 0);
        m0_req = 0;
        nxt();
        smp();
        chk("midrd_m0_rvalid_in_rst", m0_rvalid, 0);
        nxt();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("midrd_no_m0_rvalid", m0_rvalid, 0);
            chk("midrd_no_m1_rvalid", m1_rvalid, 0);
            nxt();
        end

        // Single master read of 0x0010
        m0_req = 1; m0_rw = 1; m0_addr = 16'h0010;
        smp();
        chk("single_c0_gnt", m0_gnt, 0);
        nxt();
        smp();
        chk("single_c1_gnt", m0_gnt, 1);
        chk("single_c1_addr", mem_addr, 16'h0010);
        chk("single_c1_rw", mem_rw, 1);
        nxt();
        m0_req = 0;
        smp();
        chk("single_c2_m0_rvalid", m0_rvalid, 1);
        chk("single_c2_rdata", rdata, 16'hBEEF);
        chk("single_c2_m1_rvalid", m1_rvalid, 0);
        nxt();
        smp();
        chk("single_c3_m0_rvalid", m0_rvalid, 0);

        // Contention without lock, starting from a fresh round-robin pointer
        nxt();
        reset = 1'b0;
        nxt();
        reset = 1'b1;
        m0_req = 1; m0_rw = 0; m0_addr = 16'h0020; m0_wdata = 16'h1234;
        m1_req = 1; m1_rw = 1; m1_addr = 16'h0020;
        nxt();
        smp();
        chk("cont_c1_m0_gnt", m0_gnt, 1);
        chk("cont_c1_m1_gnt", m1_gnt, 0);
        chk("cont_c1_mem_rw", mem_rw, 0);
        chk("cont_c1_wdata", mem_wdata, 16'h1234);
        nxt();
        smp();
        chk("cont_c2_m1_gnt", m1_gnt, 1);
        chk("cont_c2_mem_rw", mem_rw, 1);
        chk("cont_c2_mem_addr", mem_addr, 16'h0020);
        nxt();
        smp();
        chk("cont_c3_m0_gnt", m0_gnt, 1);
        chk("cont_c3_m1_rvalid", m1_rvalid, 1);
        chk("cont_c3_rdata", rdata, 16'h1234);
        chk("cont_c3_m0_rvalid", m0_rvalid, 0);
        nxt();
        smp();
        chk("cont_c4_m1_gnt", m1_gnt, 1);
        chk("cont_c4_m1_rvalid", m1_rvalid, 0);
        chk("cont_c4_m0_rvalid", m0_rvalid, 0);
        nxt();
        m0_req = 0; m1_req = 0;
        nxt(); nxt();

        // Lock limit: m1 locked, m0 requests, m1 keeps the bus for MAX_HOLD cycles
        m1_req = 1; m1_lock = 1; m1_rw = 1; m1_addr = 16'h0040;
        nxt();
        m0_req = 1; m0_rw = 1; m0_addr = 16'h0010;
        for (int i = 0; i < 8; i++) begin
            smp();
            chk($sformatf("lock_hold%0d_m1_gnt", i), m1_gnt, 1);
            chk($sformatf("lock_hold%0d_m0_gnt", i), m0_gnt, 0);
            nxt();
        end
        smp();
        chk("lock_forced_m0_gnt", m0_gnt, 1);
        chk("lock_forced_m1_gnt", m1_gnt, 0);
        nxt();
        m0_req = 0; m1_req = 0; m1_lock = 0;
        nxt(); nxt();

        // Handover: m0 final read of 0x0030 while m1 takes the bus to write
        m0_req = 1; m0_rw = 1; m0_addr = 16'h0030;
        nxt();
        m1_req = 1; m1_rw = 0; m1_addr = 16'h0050; m1_wdata = 16'h5A5A;
        smp();
        chk("hand_c1_m0_gnt", m0_gnt, 1);
        nxt();
        m0_req = 0;
        smp();
        chk("hand_c2_m1_gnt", m1_gnt, 1);
        chk("hand_c2_m0_rvalid", m0_rvalid, 1);
        chk("hand_c2_m1_rvalid", m1_rvalid, 0);
        chk("hand_c2_rdata", rdata, 16'hCAFE);
        chk("hand_c2_mem_rw", mem_rw, 0);
        chk("hand_c2_mem_addr", mem_addr, 16'h0050);
        chk("hand_c2_mem_wdata", mem_wdata, 16'h5A5A);
        nxt();
        m1_req = 0;
        smp();
        chk("hand_c3_written", mem_model[8'h50], 16'h5A5A);
        chk("hand_c3_m0_rvalid", m0_rvalid, 0);
        nxt(); nxt();

        // Idle parking for 10 cycles
        for (int i = 0; i < 10; i++) begin
            smp();
            chk($sformatf("park%0d_mem_rw", i), mem_rw, 1);
            chk($sformatf("park%0d_mem_addr", i), mem_addr, 0);
            chk($sformatf("park%0d_mem_wdata", i), mem_wdata, 0);
            nxt();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
